// File: rtl/nco_voice_scheduler.sv
// Multi-voice NCO scheduler: one shared synchronous sine LUT is swept across all
// voices once per sample tick, and the enabled voice codes are summed into mix_out.
module nco_voice_scheduler #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned SAMPLE_DIV = 2500,
    parameter int unsigned FCW_W      = 24,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned CODE_W     = 10
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cfg_we,
    input  logic [$clog2(NUM_VOICES)-1:0]         cfg_voice,
    input  logic [FCW_W-1:0]                      cfg_fcw,
    input  logic [NUM_VOICES-1:0]                 cfg_en,
    output logic [ADDR_W-1:0]                     lut_addr,
    input  logic [CODE_W-1:0]                     lut_data,
    output logic                                  sample_tick,
    output logic                                  busy,
    output logic [CODE_W+$clog2(NUM_VOICES)-1:0]  mix_out,
    output logic                                  mix_valid
);

    localparam int unsigned VOICE_W = $clog2(NUM_VOICES);
    localparam int unsigned MIX_W   = CODE_W + VOICE_W;
    localparam int unsigned DIV_W   = $clog2(SAMPLE_DIV);
    localparam logic [DIV_W-1:0]   LAST_DIV = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [VOICE_W-1:0] LAST_V   = VOICE_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

    state_e               state_q, state_d;
    logic [VOICE_W-1:0]   idx_q, idx_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic                 sample_tick_q;
    logic [FCW_W-1:0]     phase_q   [NUM_VOICES];
    logic [FCW_W-1:0]     fcw_sh_q  [NUM_VOICES];
    logic [FCW_W-1:0]     fcw_act_q [NUM_VOICES];
    logic [NUM_VOICES-1:0] en_sh_q, en_act_q;
    logic [ADDR_W-1:0]    lut_addr_q;
    logic [MIX_W-1:0]     acc_q, mix_out_q;
    logic                 acc_vld_q, mix_valid_q, busy_q;
    logic [VOICE_W-1:0]   acc_idx_q;

    logic                 load_active_c;
    logic                 nxt_en_c;
    logic [ADDR_W-1:0]    nxt_addr_c;
    logic [MIX_W-1:0]     acc_sum_c;

    // Next-state decode; the active config is captured only when a sweep starts
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        load_active_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (sample_tick_q) begin
                    state_d       = ISSUE;
                    idx_d         = '0;
                    load_active_c = 1'b1;
                end
            end
            ISSUE: begin
                if (idx_q == LAST_V) state_d = DRAIN;
                else                 idx_d   = VOICE_W'(idx_q + 1'b1);
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address for the voice presented next cycle; the first voice sees the shadow enable being loaded
    always_comb begin
        div_d      = (div_q == LAST_DIV) ? '0 : DIV_W'(div_q + 1'b1);
        nxt_en_c   = load_active_c ? en_sh_q[idx_d] : en_act_q[idx_d];
        nxt_addr_c = nxt_en_c ? phase_q[idx_d][FCW_W-1 -: ADDR_W] : '0;
        acc_sum_c  = acc_q;
        if (acc_vld_q && en_act_q[acc_idx_q]) acc_sum_c = MIX_W'(acc_q + MIX_W'(lut_data));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q         <= '0;
            sample_tick_q <= 1'b0;
            en_sh_q       <= '0;
            en_act_q      <= '0;
            lut_addr_q    <= '0;
            acc_q         <= '0;
            acc_vld_q     <= 1'b0;
            acc_idx_q     <= '0;
            mix_out_q     <= '0;
            mix_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            for (int i = 0; i < int'(NUM_VOICES); i++) begin
                phase_q[i]   <= '0;
                fcw_sh_q[i]  <= '0;
                fcw_act_q[i] <= '0;
            end
        end else begin
            div_q         <= div_d;
            sample_tick_q <= (div_d == LAST_DIV);
            en_sh_q       <= cfg_en;
            if (cfg_we) fcw_sh_q[cfg_voice] <= cfg_fcw;
            if (load_active_c) begin
                fcw_act_q <= fcw_sh_q;
                en_act_q  <= en_sh_q;
            end
            if (state_d == ISSUE) lut_addr_q <= nxt_addr_c;
            // Disabled voices are parked at phase zero so they restart cleanly
            if (state_q == ISSUE) begin
                phase_q[idx_q] <= en_act_q[idx_q] ? FCW_W'(phase_q[idx_q] + fcw_act_q[idx_q]) : '0;
            end
            acc_vld_q   <= (state_q == ISSUE);
            acc_idx_q   <= idx_q;
            acc_q       <= (state_q == IDLE) ? '0 : acc_sum_c;
            mix_valid_q <= (state_q == DRAIN);
            if (state_q == DRAIN) mix_out_q <= acc_sum_c;
            busy_q      <= (state_d != IDLE);
        end
    end

    assign lut_addr    = lut_addr_q;
    assign sample_tick = sample_tick_q;
    assign busy        = busy_q;
    assign mix_out     = mix_out_q;
    assign mix_valid   = mix_valid_q;

endmodule
